// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Arbitrates the single-port unified instruction/data memory
//                between the fetch stage (IF) and the memory stage (MEM).
//                MEM has priority; a starvation counter guarantees IF
//                progress after STARVE_MAX consecutive lost arbitrations.
//                Define ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT
//                cycles for ram_ready (bus_err pulse, victim rdata = 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              addr_sel,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              bus_err
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_BUSY_IF  = 2'd1;
    localparam logic [1:0] c_ST_BUSY_MEM = 2'd2;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [3:0] c_STARVE_SAT = 4'hF;

`ifdef ARB_TIMEOUT_EN
    // Abort fires on the edge at which the wait count would reach TIMEOUT.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);
`endif

    logic [1:0]        r_state_q,      w_state_d;
    logic              r_ram_en_q,     w_ram_en_d;
    logic              r_ram_we_q,     w_ram_we_d;
    logic [ADDR_W-1:0] r_ram_addr_q,   w_ram_addr_d;
    logic [DATA_W-1:0] r_ram_wdata_q,  w_ram_wdata_d;
    logic              r_addr_sel_q,   w_addr_sel_d;
    logic              r_if_valid_q,   w_if_valid_d;
    logic [DATA_W-1:0] r_if_rdata_q,   w_if_rdata_d;
    logic              r_mem_valid_q,  w_mem_valid_d;
    logic [DATA_W-1:0] r_mem_rdata_q,  w_mem_rdata_d;
    logic [3:0]        r_starve_cnt_q, w_starve_cnt_d;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]        r_wait_cnt_q,   w_wait_cnt_d;
    logic              r_bus_err_q,    w_bus_err_d;
`endif

    logic              w_mem_wins;
    logic [3:0]        w_starve_inc;

    // MEM wins unless IF is also asking and has already lost STARVE_MAX times.
    assign w_mem_wins   = mem_req && (!if_req || (r_starve_cnt_q < c_STARVE_MAX));
    assign w_starve_inc = (r_starve_cnt_q == c_STARVE_SAT) ? c_STARVE_SAT
                                                           : r_starve_cnt_q + 4'd1;

    // Next-state logic: arbitration in IDLE, completion / abort in BUSY.
    always_comb begin
        w_state_d      = r_state_q;
        w_ram_en_d     = r_ram_en_q;
        w_ram_we_d     = r_ram_we_q;
        w_ram_addr_d   = r_ram_addr_q;
        w_ram_wdata_d  = r_ram_wdata_q;
        w_addr_sel_d   = r_addr_sel_q;
        w_if_valid_d   = 1'b0;
        w_if_rdata_d   = r_if_rdata_q;
        w_mem_valid_d  = 1'b0;
        w_mem_rdata_d  = r_mem_rdata_q;
        w_starve_cnt_d = r_starve_cnt_q;
`ifdef ARB_TIMEOUT_EN
        w_wait_cnt_d   = r_wait_cnt_q;
        w_bus_err_d    = 1'b0;
`endif

        case (r_state_q)
            c_ST_IDLE: begin
                // Count only arbitrations IF actually lost; anything else clears.
                w_starve_cnt_d = (if_req && w_mem_wins) ? w_starve_inc : 4'd0;
                if (w_mem_wins) begin
                    w_state_d     = c_ST_BUSY_MEM;
                    w_ram_en_d    = 1'b1;
                    w_ram_we_d    = mem_we;
                    w_ram_addr_d  = mem_addr;
                    w_ram_wdata_d = mem_wdata;
                    w_addr_sel_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_wait_cnt_d  = 8'd0;
`endif
                end else if (if_req) begin
                    w_state_d     = c_ST_BUSY_IF;
                    w_ram_en_d    = 1'b1;
                    w_ram_we_d    = 1'b0;
                    w_ram_addr_d  = if_addr;
                    w_ram_wdata_d = '0;
                    w_addr_sel_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    w_wait_cnt_d  = 8'd0;
`endif
                end
            end

            c_ST_BUSY_IF: begin
                if (ram_ready) begin
                    w_state_d    = c_ST_IDLE;
                    w_ram_en_d   = 1'b0;
                    w_ram_we_d   = 1'b0;
                    w_if_valid_d = 1'b1;
                    w_if_rdata_d = ram_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_wait_cnt_q == c_WAIT_LAST) begin
                    w_state_d    = c_ST_IDLE;
                    w_ram_en_d   = 1'b0;
                    w_ram_we_d   = 1'b0;
                    w_if_valid_d = 1'b1;
                    w_if_rdata_d = '0;
                    w_bus_err_d  = 1'b1;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q + 8'd1;
                end
`endif
            end

            c_ST_BUSY_MEM: begin
                if (ram_ready) begin
                    w_state_d     = c_ST_IDLE;
                    w_ram_en_d    = 1'b0;
                    w_ram_we_d    = 1'b0;
                    w_mem_valid_d = 1'b1;
                    // Writes leave the last loaded word visible.
                    if (!r_ram_we_q) begin
                        w_mem_rdata_d = ram_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_wait_cnt_q == c_WAIT_LAST) begin
                    w_state_d     = c_ST_IDLE;
                    w_ram_en_d    = 1'b0;
                    w_ram_we_d    = 1'b0;
                    w_mem_valid_d = 1'b1;
                    w_mem_rdata_d = '0;
                    w_bus_err_d   = 1'b1;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q + 8'd1;
                end
`endif
            end

            default: begin
                w_state_d  = c_ST_IDLE;
                w_ram_en_d = 1'b0;
                w_ram_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= c_ST_IDLE;
            r_ram_en_q     <= 1'b0;
            r_ram_we_q     <= 1'b0;
            r_ram_addr_q   <= '0;
            r_ram_wdata_q  <= '0;
            r_addr_sel_q   <= 1'b0;
            r_if_valid_q   <= 1'b0;
            r_if_rdata_q   <= '0;
            r_mem_valid_q  <= 1'b0;
            r_mem_rdata_q  <= '0;
            r_starve_cnt_q <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            r_wait_cnt_q   <= 8'd0;
            r_bus_err_q    <= 1'b0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_ram_en_q     <= w_ram_en_d;
            r_ram_we_q     <= w_ram_we_d;
            r_ram_addr_q   <= w_ram_addr_d;
            r_ram_wdata_q  <= w_ram_wdata_d;
            r_addr_sel_q   <= w_addr_sel_d;
            r_if_valid_q   <= w_if_valid_d;
            r_if_rdata_q   <= w_if_rdata_d;
            r_mem_valid_q  <= w_mem_valid_d;
            r_mem_rdata_q  <= w_mem_rdata_d;
            r_starve_cnt_q <= w_starve_cnt_d;
`ifdef ARB_TIMEOUT_EN
            r_wait_cnt_q   <= w_wait_cnt_d;
            r_bus_err_q    <= w_bus_err_d;
`endif
        end
    end

    assign ram_en    = r_ram_en_q;
    assign ram_we    = r_ram_we_q;
    assign ram_addr  = r_ram_addr_q;
    assign ram_wdata = r_ram_wdata_q;
    assign addr_sel  = r_addr_sel_q;
    assign if_valid  = r_if_valid_q;
    assign if_rdata  = r_if_rdata_q;
    assign mem_valid = r_mem_valid_q;
    assign mem_rdata = r_mem_rdata_q;

    // Stalls release in the same cycle the valid pulse is presented.
    assign if_stall  = if_req  & ~r_if_valid_q;
    assign mem_stall = mem_req & ~r_mem_valid_q;

`ifdef ARB_TIMEOUT_EN
    assign bus_err = r_bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A transaction-level
//                reference model predicts grants and responses into queues;
//                a monitor compares them against DUT activity. Directed
//                scenarios are followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 3;
    localparam int TIMEOUT    = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              ram_ready;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              addr_sel;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_stall;
    logic              mem_stall;
    logic              bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .ram_ready(ram_ready),
        .ram_rdata(ram_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .addr_sel (addr_sel),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .mem_valid(mem_valid),
        .mem_rdata(mem_rdata),
        .if_stall (if_stall),
        .mem_stall(mem_stall),
        .bus_err  (bus_err)
    );

    typedef struct {
        bit                who;    // 1 = MEM, 0 = IF
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        bit                we;
        int                cyc;
    } grant_t;

    typedef struct {
        bit                who;
        logic [DATA_W-1:0] rdata;
        bit                err;
        int                cyc;
    } resp_t;

    grant_t gq[$];
    resp_t  rq[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int n_if_done = 0;
    int n_mem_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit                m_busy  = 1'b0;
    bit                m_owner = 1'b0;
    bit                m_we    = 1'b0;
    int                m_starve = 0;
    int                m_wait   = 0;
    logic [DATA_W-1:0] m_mem_rdata = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy      = 1'b0;
            m_starve    = 0;
            m_mem_rdata = '0;
        end else if (!m_busy) begin
            if (mem_req && (!if_req || m_starve < STARVE_MAX)) begin
                gq.push_back('{who: 1'b1, addr: mem_addr, wdata: mem_wdata, we: mem_we, cyc: cyc});
                m_busy   = 1'b1;
                m_owner  = 1'b1;
                m_we     = mem_we;
                m_wait   = 0;
                m_starve = if_req ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
            end else if (if_req) begin
                gq.push_back('{who: 1'b0, addr: if_addr, wdata: '0, we: 1'b0, cyc: cyc});
                m_busy   = 1'b1;
                m_owner  = 1'b0;
                m_we     = 1'b0;
                m_wait   = 0;
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end else if (ram_ready) begin
            if (m_owner && !m_we) m_mem_rdata = ram_rdata;
            rq.push_back('{who: m_owner, rdata: (m_owner ? m_mem_rdata : ram_rdata), err: 1'b0, cyc: cyc});
            m_busy = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
                if (m_owner) m_mem_rdata = '0;
                rq.push_back('{who: m_owner, rdata: '0, err: 1'b1, cyc: cyc});
                m_busy = 1'b0;
            end
        end
`endif
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check_resp(input bit who, input logic [DATA_W-1:0] rdata);
        resp_t r;
        if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=who%0d required=none (cycle %0d)", who, cyc);
        end else begin
            r = rq.pop_front();
            check("resp_who",   32'(who),    32'(r.who));
            check("resp_rdata", 32'(rdata),  32'(r.rdata));
            check("resp_cycle", 32'(cyc),    32'(r.cyc));
            check("resp_buserr", 32'(bus_err), 32'(r.err));
        end
    endtask

    initial begin : p_monitor
        bit                mon_prev_en = 1'b0;
        logic [ADDR_W-1:0] cur_addr    = '0;
        grant_t            g;
        forever begin
            @(posedge clk);
            #1;
            if (ram_en && !mon_prev_en) begin
                if (gq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual=sel%0d required=none (cycle %0d)", addr_sel, cyc);
                end else begin
                    g = gq.pop_front();
                    cur_addr = g.addr;
                    check("grant_sel",   32'(addr_sel), 32'(g.who));
                    check("grant_addr",  32'(ram_addr), 32'(g.addr));
                    check("grant_cycle", 32'(cyc),      32'(g.cyc));
                    check("grant_we",    32'(ram_we),   32'(g.we));
                    if (g.who) check("grant_wdata", 32'(ram_wdata), 32'(g.wdata));
                end
            end
            if (gq.size() > 0 && gq[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_grant actual=none required=sel%0d (cycle %0d)", gq[0].who, cyc);
                void'(gq.pop_front());
            end
            if (ram_en) check("hold_addr", 32'(ram_addr), 32'(cur_addr));

            if (if_valid) begin
                n_if_done++;
                check_resp(1'b0, if_rdata);
            end
            if (mem_valid) begin
                n_mem_done++;
                check_resp(1'b1, mem_rdata);
            end
            if (!if_valid && !mem_valid) check("bus_err_quiet", 32'(bus_err), 32'd0);
            if (rq.size() > 0 && rq[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_valid actual=none required=who%0d (cycle %0d)", rq[0].who, cyc);
                void'(rq.pop_front());
            end

            check("if_stall",  32'(if_stall),  32'(if_req & ~if_valid));
            check("mem_stall", 32'(mem_stall), 32'(mem_req & ~mem_valid));
            mon_prev_en = ram_en;
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_tick();
        @(negedge clk);
        rst = ($urandom_range(0, 299) == 0);
        if (!if_req || if_valid)   if_req  = ($urandom_range(0, 2) != 0);
        if (!mem_req || mem_valid) mem_req = ($urandom_range(0, 2) != 0);
        if_addr   = ADDR_W'($urandom);
        mem_addr  = ADDR_W'($urandom);
        mem_we    = $urandom_range(0, 1) != 0;
        mem_wdata = DATA_W'($urandom);
        ram_rdata = DATA_W'($urandom);
        ram_ready = ram_en ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
    endtask

    bit exp_order[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit got_order[8];

    initial begin : p_main
        int  n;
        bit  prev;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_ready = 1'b0; ram_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ram_en",    32'(ram_en),    32'd0);
        check("rst_addr_sel",  32'(addr_sel),  32'd0);
        check("rst_ram_addr",  32'(ram_addr),  32'd0);
        check("rst_mem_rdata", 32'(mem_rdata), 32'd0);
        check("rst_bus_err",   32'(bus_err),   32'd0);
        rst = 1'b0;

        // Solo IF read.
        @(negedge clk); if_req = 1'b1; if_addr = 20'h00010;
        @(posedge clk); #1;
        check("if_grant_sel",  32'(addr_sel), 32'd0);
        check("if_grant_addr", 32'(ram_addr), 32'h00010);
        check("if_stall_busy", 32'(if_stall), 32'd1);
        @(negedge clk); ram_ready = 1'b1; ram_rdata = 16'h1234;
        @(posedge clk); #1;
        check("if_valid_pulse", 32'(if_valid), 32'd1);
        check("if_rdata_val",   32'(if_rdata), 32'h1234);
        check("if_stall_done",  32'(if_stall), 32'd0);
        @(negedge clk); ram_ready = 1'b0; if_req = 1'b0;

        // Simultaneous requests: MEM write first, then IF after the bubble.
        @(negedge clk);
        if_req = 1'b1; if_addr = 20'h00040;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 20'h00020; mem_wdata = 16'hBEEF;
        @(posedge clk); #1;
        check("sim_sel_mem",  32'(addr_sel),  32'd1);
        check("sim_we",       32'(ram_we),    32'd1);
        check("sim_addr",     32'(ram_addr),  32'h00020);
        check("sim_wdata",    32'(ram_wdata), 32'hBEEF);
        @(negedge clk); ram_ready = 1'b1;
        @(posedge clk); #1;
        check("sim_mem_valid", 32'(mem_valid), 32'd1);
        @(negedge clk); ram_ready = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        @(posedge clk); #1;
        check("sim_sel_if",  32'(addr_sel), 32'd0);
        check("sim_if_addr", 32'(ram_addr), 32'h00040);
        @(negedge clk); ram_ready = 1'b1; ram_rdata = 16'h0F0F;
        @(posedge clk); #1;
        check("sim_if_valid", 32'(if_valid), 32'd1);
        @(negedge clk); ram_ready = 1'b0; if_req = 1'b0;
        @(negedge clk);

        // Starvation guard: continuous requests from both sides.
        if_req = 1'b1; if_addr = 20'h00100; mem_req = 1'b1; mem_we = 1'b0;
        mem_addr = 20'h00200; ram_ready = 1'b1; ram_rdata = 16'h0042;
        n = 0; prev = ram_en;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(posedge clk); #1;
            if (ram_en && !prev) begin
                got_order[n] = addr_sel;
                n++;
            end
            prev = ram_en;
        end
        check("starve_grants", 32'(n), 32'd8);
        for (int i = 0; i < 8; i++) check("starve_order", 32'(got_order[i]), 32'(exp_order[i]));
        @(negedge clk); mem_req = 1'b0;
        @(negedge clk); if_req = 1'b0; ram_ready = 1'b0;
        @(negedge clk);

        // Inputs change while MEM access is in flight.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00111;
        @(posedge clk); #1;
        @(negedge clk); mem_addr = 20'h00999; mem_req = 1'b0;
        @(posedge clk); #1;
        check("chg_addr_held", 32'(ram_addr), 32'h00111);
        check("chg_en_held",   32'(ram_en),   32'd1);
        @(negedge clk); ram_ready = 1'b1; ram_rdata = 16'h5A5A;
        @(posedge clk); #1;
        check("chg_mem_valid", 32'(mem_valid), 32'd1);
        check("chg_mem_rdata", 32'(mem_rdata), 32'h5A5A);
        @(negedge clk); ram_ready = 1'b0;
        @(posedge clk); #1;
        check("chg_valid_once", 32'(mem_valid), 32'd0);

        // Reset in the middle of a MEM write.
        @(negedge clk); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 20'h00077; mem_wdata = 16'h1111;
        @(posedge clk); #1;
        check("rstmid_grant", 32'(ram_en), 32'd1);
        @(negedge clk); rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; ram_ready = 1'b1;
        @(posedge clk); #1;
        check("rstmid_ram_en",    32'(ram_en),    32'd0);
        check("rstmid_ram_we",    32'(ram_we),    32'd0);
        check("rstmid_ram_addr",  32'(ram_addr),  32'd0);
        check("rstmid_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rstmid_mem_valid", 32'(mem_valid), 32'd0);
        check("rstmid_mem_rdata", 32'(mem_rdata), 32'd0);
        check("rstmid_if_rdata",  32'(if_rdata),  32'd0);
        @(negedge clk); ram_ready = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: abort TIMEOUT cycles after the grant.
        @(negedge clk); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00333;
        @(posedge clk); #1;
        check("to_grant", 32'(ram_en), 32'd1);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("to_not_yet", 32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        check("to_mem_valid", 32'(mem_valid), 32'd1);
        check("to_bus_err",   32'(bus_err),   32'd1);
        check("to_mem_rdata", 32'(mem_rdata), 32'd0);
        check("to_ram_en",    32'(ram_en),    32'd0);
        @(negedge clk); mem_req = 1'b0;
`endif

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) rand_tick();

        // Drain: let any access in flight complete.
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; ram_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("drain_grant_q", 32'(gq.size()), 32'd0);
        check("drain_resp_q",  32'(rq.size()), 32'd0);
        check("if_traffic",    32'(n_if_done > 10),  32'd1);
        check("mem_traffic",   32'(n_mem_done > 10), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the five-stage pipeline.
- Picks a winner each arbitration and latches its address and write data.
- Drives the address-mux select and a memory handshake.
- Returns read data and stall signals to both stages.
- MEM has priority; a starvation guard ensures IF always makes progress.

Parameters:
- ADDR_W, 20, width of the memory address.
- DATA_W, 16, width of the memory data.
- STARVE_MAX, 3, number of consecutive lost arbitrations after which IF wins; range 1-15.
- TIMEOUT, 15, cycles to wait for ram_ready before abort; used only with ARB_TIMEOUT_EN; range 1-255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address.
- mem_req  in  1  memory-stage request.
- mem_we  in  1  memory-stage write (1) or read (0).
- mem_addr  in  ADDR_W  memory-stage address.
- mem_wdata  in  DATA_W  memory-stage write data.
- ram_ready  in  1  memory completes the current access this cycle.
- ram_rdata  in  DATA_W  memory read data; valid when ram_ready=1.
- ram_en  out  1  access in progress.
- ram_we  out  1  write strobe, qualified by ram_en.
- ram_addr  out  ADDR_W  latched address.
- ram_wdata  out  DATA_W  latched write data.
- addr_sel  out  1  address-mux select: 0 = IF, 1 = MEM.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched word.
- mem_valid  out  1  one-cycle pulse; MEM access done, mem_rdata valid on reads.
- mem_rdata  out  DATA_W  loaded word.
- if_stall  out  1  freeze the fetch stage.
- mem_stall  out  1  freeze the memory stage.
- bus_err  out  1  timeout pulse; tied to 0 without the macro.

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_MEM. State, registers and counters change only on the clk rising edge.
- Reset: rst=1 at a clock edge has the following effect:
  - state returns to IDLE;
  - ram_en, ram_we, addr_sel, if_valid and mem_valid go to 0;
  - ram_addr, ram_wdata, if_rdata and mem_rdata go to 0;
  - bus_err goes to 0;
  - the starvation counter goes to 0.
- Reset mid-access abandons the access. No valid pulse is produced, and a ram_ready arriving afterwards in IDLE is ignored.
- Arbitration happens only in IDLE:
  - mem_req=1 and (if_req=0 or starve_cnt<STARVE_MAX): grant MEM and go to BUSY_MEM.
  - Otherwise, if if_req=1: grant IF and go to BUSY_IF.
  - No request: stay in IDLE.
- Starvation counter (4-bit):
  - increments, saturating, when both requests are present and MEM wins;
  - clears when IF is granted, or when if_req=0 in IDLE.
- On a grant, at the same edge:
  - ram_addr and ram_wdata latch the winner's address and data;
  - ram_we latches mem_we for MEM, 0 for IF;
  - addr_sel latches 1 for MEM, 0 for IF;
  - ram_en goes to 1.
- The latched values are held for the whole BUSY state, so requester inputs may change during it.
- In BUSY_x with ram_ready=1, at that edge:
  - x_valid goes to 1 for exactly one cycle;
  - x_rdata captures ram_rdata (mem_rdata is unchanged on writes);
  - ram_en and ram_we go to 0;
  - state returns to IDLE.
- Access latency:
  - minimum is grant edge + 1 cycle with ram_ready, i.e. valid appears 2 cycles after the request is first seen in IDLE;
  - there is one IDLE bubble between back-to-back accesses.
- In BUSY_x with ram_ready=0: the state holds indefinitely. This applies when ARB_TIMEOUT_EN is not defined.
- Stalls are combinational:
  - if_stall = if_req & ~if_valid;
  - mem_stall = mem_req & ~mem_valid.
  - A requester must hold its req high until its valid pulse. Dropping req mid-access does not cancel the access.
- Simultaneous events:
  - ram_ready together with new requests: the completion takes effect and arbitration waits for the next IDLE cycle.
  - rst has priority over everything.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - an 8-bit wait counter clears on every grant and increments each BUSY cycle with ram_ready=0;
  - when it reaches TIMEOUT, the access is aborted: state goes to IDLE, ram_en=0, ram_we=0;
  - bus_err pulses for 1 cycle and the victim's valid also pulses, with its rdata forced to 0, so the pipeline unfreezes;
  - ram_ready on the abort edge counts as a normal completion, and the timeout is not flagged.
- Not defined: no wait counter; bus_err is constant 0; BUSY waits forever.

Test Plan:
- rst held 2 cycles mid-BUSY_MEM, then ram_ready=1 → all outputs 0, state IDLE, no valid pulse.
- Solo IF read, if_addr=0x00010, ram_ready one cycle after grant with ram_rdata=0x1234:
  - addr_sel=0, ram_addr=0x00010;
  - if_valid pulses 2 cycles after the request with if_rdata=0x1234;
  - if_stall is high until that pulse.
- Simultaneous if_req and mem_req (write, addr 0x00020, data 0xBEEF) → MEM granted first with ram_we=1, addr_sel=1; then IF is granted after the IDLE bubble.
- Continuous mem_req and if_req, STARVE_MAX=3 → grant order MEM, MEM, MEM, IF, MEM, MEM, MEM, IF.
- Input change during access: mem_addr changed and mem_req dropped during BUSY_MEM → ram_addr stays at the latched value and mem_valid still pulses once.
- With ARB_TIMEOUT_EN, TIMEOUT=15, ram_ready never asserted → bus_err and mem_valid pulse together 15 cycles after the grant, mem_rdata=0, state IDLE.
